// File: rtl/cc_io_hub.sv
// cc_io_hub: port-mapped I/O hub with output registers, input channels and an interrupt controller.
// Optional macro CC_IO_HUB_KPORT_EN enables constant-port (kwrite_strobe) writes to the output registers.
module cc_io_hub #(
    parameter int         NUM_OUT  = 4,
    parameter int         NUM_IN   = 4,
    parameter int         NUM_IRQ  = 4,
    parameter logic [7:0] OUT_BASE = 8'h00,
    parameter logic [7:0] IN_BASE  = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           port_id,
    input  logic [7:0]           port_out,
    input  logic                 write_strobe,
    input  logic                 kwrite_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           port_in,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    output logic [8*NUM_OUT-1:0] out_data,
    output logic [NUM_OUT-1:0]   out_stb,
    input  logic [8*NUM_IN-1:0]  in_data,
    output logic [NUM_IN-1:0]    in_stb,
    input  logic [NUM_IRQ-1:0]   irq_src
);

    localparam logic [7:0] ADDR_PEND = 8'hF0;
    localparam logic [7:0] ADDR_MASK = 8'hF1;
    localparam logic [7:0] ADDR_VEC  = 8'hF2;
    localparam logic [7:0] ADDR_ID   = 8'hF3;
    localparam logic [7:0] IRQ_BITS  = 8'((1 << NUM_IRQ) - 1);
    localparam logic [7:0] HUB_ID    = {4'(NUM_IN - 1), 4'(NUM_OUT - 1)};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        SERVICED = 2'd2
    } irq_state_t;

    irq_state_t           state;
    irq_state_t           state_next;
    logic                 int_next;

    logic [NUM_OUT-1:0]   out_sel;
    logic [NUM_OUT-1:0]   out_we;
    logic [NUM_IN-1:0]    in_sel;
    logic                 out_hit;
    logic                 in_hit;
    logic                 pend_wr;
    logic                 mask_wr;
    logic [7:0]           rd_data;

    logic [NUM_IRQ-1:0]   sync1;
    logic [NUM_IRQ-1:0]   sync2;
    logic [NUM_IRQ-1:0]   hist;
    logic [1:0]           warm;
    logic [NUM_IRQ-1:0]   rise_v;
    logic [7:0]           rise_w;
    logic [7:0]           pend;
    logic [7:0]           mask;
    logic [7:0]           active;
    logic [7:0]           vec;

    // Output registers win over input channels, which win over the fixed registers.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            out_sel[i] = (port_id == (OUT_BASE + 8'(i)));
        end
        out_hit = |out_sel;
        for (int i = 0; i < NUM_IN; i++) begin
            in_sel[i] = !out_hit && (port_id == (IN_BASE + 8'(i)));
        end
        in_hit  = |in_sel;
        pend_wr = write_strobe && !out_hit && !in_hit && (port_id == ADDR_PEND);
        mask_wr = write_strobe && !out_hit && !in_hit && (port_id == ADDR_MASK);
    end

`ifdef CC_IO_HUB_KPORT_EN
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            out_we[i] = (write_strobe && out_sel[i]) ||
                        (kwrite_strobe && (port_id[3:0] == 4'(i)));
        end
    end
`else
    logic unused_kwrite;
    assign unused_kwrite = kwrite_strobe;

    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            out_we[i] = write_strobe && out_sel[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_stb  <= '0;
        end else begin
            out_stb <= out_we;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_we[i]) begin
                    out_data[8*i +: 8] <= port_out;
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (port_id)
            ADDR_PEND: rd_data = pend;
            ADDR_MASK: rd_data = mask;
            ADDR_VEC:  rd_data = vec;
            ADDR_ID:   rd_data = HUB_ID;
            default:   rd_data = 8'h00;
        endcase
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel[i]) rd_data = in_data[8*i +: 8];
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_sel[i]) rd_data = out_data[8*i +: 8];
        end
    end

    // port_in follows port_id every cycle; only in_stb depends on read_strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_in <= 8'h00;
            in_stb  <= '0;
        end else begin
            port_in <= rd_data;
            in_stb  <= read_strobe ? in_sel : '0;
        end
    end

    // Edges are suppressed until the synchroniser and history hold real samples,
    // so a source already high at reset release never raises a pending bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            warm  <= 2'd0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            hist  <= sync2;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    always_comb begin
        rise_v                = (warm == 2'd3) ? (sync2 & ~hist) : '0;
        rise_w                = '0;
        rise_w[NUM_IRQ-1:0]   = rise_v;
    end

    // A new edge is OR-ed in after the clear, so set wins over write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 8'h00;
            mask <= 8'h00;
        end else begin
            pend <= ((pend & ~(pend_wr ? port_out : 8'h00)) | rise_w) & IRQ_BITS;
            if (mask_wr) mask <= port_out & IRQ_BITS;
        end
    end

    assign active = pend & mask;

    always_comb begin
        vec = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) vec = 8'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= int_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (active != 8'h00) state_next = REQ;
            REQ: begin
                if (active == 8'h00)    state_next = IDLE;
                else if (interrupt_ack) state_next = SERVICED;
            end
            SERVICED: if (pend_wr || mask_wr) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        int_next = (state_next == REQ);
    end

endmodule

// File: tb/tb_cc_io_hub.sv
// Self-checking bench for cc_io_hub: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cc_io_hub;

    logic        clk;
    logic        reset_n;
    logic [7:0]  port_id;
    logic [7:0]  port_out;
    logic        write_strobe;
    logic        kwrite_strobe;
    logic        read_strobe;
    logic [7:0]  port_in;
    logic        interrupt;
    logic        interrupt_ack;
    logic [31:0] out_data;
    logic [3:0]  out_stb;
    logic [31:0] in_data;
    logic [3:0]  in_stb;
    logic [3:0]  irq_src;

    int n_vec;
    int n_err;

    // behavioural model state
    logic [7:0] m_out [4];
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    int         m_mode;  // 0 idle, 1 requesting, 2 serviced
    logic [7:0] m_port_in;
    logic [3:0] m_out_stb;
    logic [3:0] m_in_stb;
    logic       m_int;
    logic [3:0] src_q[$];

    cc_io_hub dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .port_out      (port_out),
        .write_strobe  (write_strobe),
        .kwrite_strobe (kwrite_strobe),
        .read_strobe   (read_strobe),
        .port_in       (port_in),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .out_data      (out_data),
        .out_stb       (out_stb),
        .in_data       (in_data),
        .in_stb        (in_stb),
        .irq_src       (irq_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_pend    = 8'h00;
        m_mask    = 8'h00;
        m_mode    = 0;
        m_port_in = 8'h00;
        m_out_stb = 4'h0;
        m_in_stb  = 4'h0;
        m_int     = 1'b0;
        src_q.delete();
    endtask

    function automatic logic [7:0] m_vec();
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && m_mask[i]) return 8'(i);
        end
        return 8'hFF;
    endfunction

    task automatic model_edge();
        logic [7:0] act;
        logic [7:0] w1c;
        logic [3:0] rise;
        int         k;
        int         idx;
        idx = int'(port_id[1:0]);
        m_port_in = 8'h00;
        if (port_id < 8'h04) m_port_in = m_out[idx];
        else if (port_id >= 8'h20 && port_id < 8'h24) m_port_in = in_data[idx*8 +: 8];
        else if (port_id == 8'hF0) m_port_in = m_pend;
        else if (port_id == 8'hF1) m_port_in = m_mask;
        else if (port_id == 8'hF2) m_port_in = m_vec();
        else if (port_id == 8'hF3) m_port_in = 8'h33;
        m_in_stb = 4'h0;
        if (read_strobe && port_id >= 8'h20 && port_id < 8'h24) m_in_stb[idx] = 1'b1;
        m_out_stb = 4'h0;
        if (write_strobe && port_id < 8'h04) m_out_stb[idx] = 1'b1;
`ifdef CC_IO_HUB_KPORT_EN
        if (kwrite_strobe && port_id[3:0] < 4'd4) m_out_stb[idx] = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            if (m_out_stb[i]) m_out[i] = port_out;
        end
        // a source sample becomes a pending bit two edges after it is taken,
        // and only once three samples exist since reset release
        act = m_pend & m_mask;
        src_q.push_back(irq_src);
        k = src_q.size();
        rise = (k >= 4) ? (src_q[k-3] & ~src_q[k-4]) : 4'h0;
        w1c = (write_strobe && port_id == 8'hF0) ? port_out : 8'h00;
        case (m_mode)
            0: if (act != 0) m_mode = 1;
            1: if (act == 0) m_mode = 0; else if (interrupt_ack) m_mode = 2;
            default: if (write_strobe && (port_id == 8'hF0 || port_id == 8'hF1)) m_mode = 0;
        endcase
        m_pend = ((m_pend & ~w1c) | {4'h0, rise}) & 8'h0F;
        if (write_strobe && port_id == 8'hF1) m_mask = port_out & 8'h0F;
        m_int = (m_mode == 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("port_in", 32'(port_in), 32'(m_port_in));
        chk("out_stb", 32'(out_stb), 32'(m_out_stb));
        chk("in_stb", 32'(in_stb), 32'(m_in_stb));
        chk("interrupt", 32'(interrupt), 32'(m_int));
        chk("out_data", out_data, {m_out[3], m_out[2], m_out[1], m_out[0]});
    endtask

    task automatic idle_inputs();
        write_strobe  = 1'b0;
        kwrite_strobe = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        port_out     = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a);
        port_id     = a;
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_port_in"}, 32'(port_in), 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_out_stb"}, 32'(out_stb), 32'h0);
        chk({tag, "_in_stb"}, 32'(in_stb), 32'h0);
        chk({tag, "_interrupt"}, 32'(interrupt), 32'h0);
    endtask

    logic [7:0] addr_tab [14];

    initial begin
        addr_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21,
                     8'h22, 8'h23, 8'h24, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        port_id  = 8'h00;
        port_out = 8'h00;
        in_data  = 32'h0;
        irq_src  = 4'h0;
        idle_inputs();
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) step();

        // output register write and read-back
        do_write(8'h01, 8'hA5);
        chk("wr_byte1", 32'(out_data[15:8]), 32'hA5);
        chk("wr_stb", 32'(out_stb), 32'h2);
        step();
        chk("wr_stb_drop", 32'(out_stb), 32'h0);
        do_read(8'h01);
        chk("rd_back", 32'(port_in), 32'hA5);

        // input channel read
        in_data = 32'h003C_0000;
        do_read(8'h22);
        chk("rd_ch2", 32'(port_in), 32'h3C);
        chk("rd_ch2_stb", 32'(in_stb), 32'h4);
        step();
        chk("rd_ch2_stb_drop", 32'(in_stb), 32'h0);
        do_read(8'hF3);
        chk("hub_id", 32'(port_in), 32'h33);
        do_read(8'h07);
        chk("unmapped", 32'(port_in), 32'h00);
        do_read(8'hF2);
        chk("vec_none", 32'(port_in), 32'hFF);

        // interrupt flow
        do_write(8'hF1, 8'h0C);
        irq_src = 4'b1000; repeat (2) step();
        irq_src = 4'b0000; repeat (2) step();
        irq_src = 4'b0100; repeat (2) step();
        irq_src = 4'b0000; repeat (5) step();
        do_read(8'hF0);
        chk("pend_0c", 32'(port_in), 32'h0C);
        do_read(8'hF2);
        chk("vec_2", 32'(port_in), 32'h02);
        chk("int_high", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        chk("int_acked", 32'(interrupt), 32'h0);
        do_write(8'hF0, 8'h04);
        chk("int_after_w1c", 32'(interrupt), 32'h0);
        step();
        chk("int_reassert", 32'(interrupt), 32'h1);
        do_read(8'hF2);
        chk("vec_3", 32'(port_in), 32'h03);

        // asynchronous reset while busy, sources held high through release
        irq_src = 4'hF;
        step();
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        repeat (8) step();
        do_read(8'hF0);
        chk("no_pend_after_rst", 32'(port_in), 32'h00);

        // edge and write-1-to-clear on the same bit in the same cycle
        irq_src = 4'h0;
        repeat (4) step();
        irq_src = 4'b0010;
        repeat (2) step();
        do_write(8'hF0, 8'h02);
        do_read(8'hF0);
        chk("set_wins", 32'(port_in[1]), 32'h1);
        do_write(8'hF0, 8'h02);
        do_read(8'hF0);
        chk("w1c_clears", 32'(port_in), 32'h00);

        // constant-port write
        do_write(8'h03, 8'h11);
        port_id       = 8'h03;
        port_out      = 8'h7E;
        kwrite_strobe = 1'b1;
        step();
        kwrite_strobe = 1'b0;
`ifdef CC_IO_HUB_KPORT_EN
        chk("kwrite", 32'(out_data[31:24]), 32'h7E);
`else
        chk("kwrite_ignored", 32'(out_data[31:24]), 32'h11);
`endif

        // randomized traffic
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) port_id = 8'($urandom);
            else port_id = addr_tab[$urandom_range(0, 13)];
            port_out      = 8'($urandom);
            write_strobe  = ($urandom_range(0, 2) == 0);
            kwrite_strobe = ($urandom_range(0, 7) == 0);
            read_strobe   = ($urandom_range(0, 1) == 0);
            interrupt_ack = ($urandom_range(0, 3) == 0);
            in_data       = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
